instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 195 +++++++++++++++++++
 tb/tb_instruction_fetch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues instruction-memory reads, holds one fetched word for decode
// and follows branch redirects. Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets.
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_error
);

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {FETCH, HOLD, DROP, ERR} state_t;
`else
    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] reqAddr_q, reqAddr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instrPc_q, instrPc_d;
    logic        instrValid_q, instrValid_d;
    logic [31:0] redirTarget;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;
    logic errPend_q, errPend_d;

    assign misaligned  = (redirect_pc[1:0] != 2'b00);
    assign redirTarget = redirect_pc;
    assign fetch_error = (state_q == ERR);
`else
    assign redirTarget = redirect_pc & 32'hFFFF_FFFC;
    assign fetch_error = 1'b0;
`endif

    assign instr       = instr_q;
    assign instr_pc    = instrPc_q;
    assign instr_valid = instrValid_q;

    // The request is gated by rst_n so it drops the instant reset asserts, without waiting for an ack.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = 32'h0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    imem_req  = 1'b1;
                    imem_addr = pc_q;
                end
                DROP: begin
                    imem_req  = 1'b1;
                    imem_addr = reqAddr_q;
                end
                default: begin
                    imem_req  = 1'b0;
                    imem_addr = 32'h0;
                end
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        reqAddr_d    = reqAddr_q;
        instr_d      = instr_q;
        instrPc_d    = instrPc_q;
        instrValid_d = instrValid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        errPend_d    = errPend_q;
`endif
        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    if (!imem_ack) begin
                        reqAddr_d = pc_q;
                        state_d   = DROP;
                    end
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (misaligned) begin
                        if (imem_ack) begin
                            state_d = ERR;
                        end else begin
                            errPend_d = 1'b1;
                        end
                    end else begin
                        pc_d      = redirTarget;
                        errPend_d = 1'b0;
                    end
`else
                    pc_d = redirTarget;
`endif
                end else if (imem_ack) begin
                    instr_d      = imem_rdata;
                    instrPc_d    = pc_q;
                    pc_d         = pc_q + 32'd4;
                    instrValid_d = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    instrValid_d = 1'b0;
                    state_d      = FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (misaligned) begin
                        state_d = ERR;
                    end else begin
                        pc_d = redirTarget;
                    end
`else
                    pc_d = redirTarget;
`endif
                end else if (instr_ready) begin
                    instrValid_d = 1'b0;
                    state_d      = FETCH;
                end
            end
            DROP: begin
                // The stale request must still complete on the bus; its data is thrown away.
                if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (misaligned) begin
                        errPend_d = 1'b1;
                    end else begin
                        pc_d      = redirTarget;
                        errPend_d = 1'b0;
                    end
`else
                    pc_d = redirTarget;
`endif
                end
                if (imem_ack) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    state_d   = errPend_d ? ERR : FETCH;
                    errPend_d = 1'b0;
`else
                    state_d = FETCH;
`endif
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            ERR: begin
                if (redirect_valid && !misaligned) begin
                    pc_d    = redirTarget;
                    state_d = FETCH;
                end
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_VECTOR;
            reqAddr_q    <= 32'h0;
            instr_q      <= 32'h0;
            instrPc_q    <= 32'h0;
            instrValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            reqAddr_q    <= reqAddr_d;
            instr_q      <= instr_d;
            instrPc_q    <= instrPc_d;
            instrValid_q <= instrValid_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errPend_q <= 1'b0;
        end else begin
            errPend_q <= errPend_d;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios push expected bus acks and delivered
// instructions into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } instrExp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_error;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] expAddrQ[$];
    instrExp_t   expInstrQ[$];
    instrExp_t   monExp;

    int   acksLeft = 0;
    int   waitCnt  = 0;
    int   ackDelay = 1;
    logic readyOn  = 1'b1;

    instruction_fetch #(.RESET_VECTOR(RESET_VECTOR)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .fetch_error    (fetch_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    // One clock: inputs change 1ns after the edge; the memory model acks after ackDelay waiting cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        if (imem_req && acksLeft > 0 && waitCnt >= ackDelay) begin
            imem_ack   = 1'b1;
            imem_rdata = {16'hC0DE, imem_addr[15:0]};
            acksLeft--;
            waitCnt    = 0;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_DEAD;
            if (imem_req) waitCnt++;
            else waitCnt = 0;
        end
        instr_ready = readyOn;
    endtask

    task automatic applyStimulus(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    task automatic pushInstr(input logic [31:0] pc, input logic [31:0] data);
        instrExp_t e;
        e.pc   = pc;
        e.data = data;
        expInstrQ.push_back(e);
    endtask

    task automatic waitDrain(input string name, input int maxCycles);
        int n = 0;
        while ((expAddrQ.size() != 0 || expInstrQ.size() != 0) && n < maxCycles) begin
            tick();
            n++;
        end
        if (expAddrQ.size() != 0 || expInstrQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s timeout: %0d acks and %0d instrs outstanding, expected 0",
                     name, expAddrQ.size(), expInstrQ.size());
            expAddrQ.delete();
            expInstrQ.delete();
        end
    endtask

    task automatic waitValid(input string name, input int maxCycles);
        int n = 0;
        while (!instr_valid && n < maxCycles) begin
            tick();
            n++;
        end
        checkFlag({name, "_valid_seen"}, instr_valid, 1'b1);
    endtask

    // Monitor: every completed bus read and every accepted instruction is matched against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req && imem_ack) begin
                if (expAddrQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_ack: addr %h, expected no request", imem_addr);
                end else begin
                    checkOutput("ack_addr", imem_addr, expAddrQ.pop_front());
                end
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                if (expInstrQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_instr: pc %h, expected no delivery", instr_pc);
                end else begin
                    monExp = expInstrQ.pop_front();
                    checkOutput("instr_pc", instr_pc, monExp.pc);
                    checkOutput("instr", instr, monExp.data);
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkFlag("rst_req", imem_req, 1'b0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        checkFlag("rst_valid", instr_valid, 1'b0);
        checkFlag("rst_error", fetch_error, 1'b0);

        // Sequential fetch from the reset vector.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkFlag("first_req", imem_req, 1'b1);
        checkOutput("first_addr", imem_addr, 32'h100);
        acksLeft = 3;
        expAddrQ.push_back(32'h100);
        expAddrQ.push_back(32'h104);
        expAddrQ.push_back(32'h108);
        pushInstr(32'h100, 32'hC0DE_0100);
        pushInstr(32'h104, 32'hC0DE_0104);
        pushInstr(32'h108, 32'hC0DE_0108);
        waitDrain("seq_fetch", 40);
        checkOutput("seq_next_addr", imem_addr, 32'h10C);

        // Downstream stall in HOLD.
        readyOn     = 1'b0;
        instr_ready = 1'b0;
        acksLeft    = 1;
        expAddrQ.push_back(32'h10C);
        pushInstr(32'h10C, 32'hC0DE_010C);
        waitValid("stall", 20);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_instr", instr, 32'hC0DE_010C);
            checkOutput("stall_instr_pc", instr_pc, 32'h10C);
            checkFlag("stall_valid", instr_valid, 1'b1);
            checkFlag("stall_req", imem_req, 1'b0);
        end
        readyOn     = 1'b1;
        instr_ready = 1'b1;
        waitDrain("stall_release", 20);
        checkOutput("stall_next_addr", imem_addr, 32'h110);

        // Reset asserted while a request is outstanding.
        #2;
        rst_n = 1'b0;
        #1;
        checkFlag("midrst_req", imem_req, 1'b0);
        checkOutput("midrst_addr", imem_addr, 32'h0);
        checkFlag("midrst_valid", instr_valid, 1'b0);
        @(negedge clk);
        rst_n   = 1'b1;
        waitCnt = 0;
        #1;
        checkOutput("rerst_addr", imem_addr, 32'h100);

        // Redirect while the request to 0x104 is outstanding; its data must be dropped.
        acksLeft = 1;
        expAddrQ.push_back(32'h100);
        pushInstr(32'h100, 32'hC0DE_0100);
        waitDrain("refetch", 20);
        checkOutput("pre_redirect_addr", imem_addr, 32'h104);
        applyStimulus(32'h200);
        checkFlag("drop_req", imem_req, 1'b1);
        checkOutput("drop_addr", imem_addr, 32'h104);
        tick();
        checkOutput("drop_addr_held", imem_addr, 32'h104);
        acksLeft = 2;
        expAddrQ.push_back(32'h104);
        expAddrQ.push_back(32'h200);
        pushInstr(32'h200, 32'hC0DE_0200);
        tick();
        tick();
        checkOutput("post_drop_addr", imem_addr, 32'h200);
        checkFlag("post_drop_valid", instr_valid, 1'b0);
        waitDrain("redirect_drop", 20);

        // Redirect in the same cycle as imem_ack.
        acksLeft = 1;
        expAddrQ.push_back(32'h204);
        tick();
        applyStimulus(32'h300);
        checkFlag("redir_ack_valid", instr_valid, 1'b0);
        checkOutput("redir_ack_addr", imem_addr, 32'h300);
        acksLeft = 1;
        expAddrQ.push_back(32'h300);
        pushInstr(32'h300, 32'hC0DE_0300);
        waitDrain("redir_ack", 20);

        // Redirect in the same cycle as instr_ready in HOLD.
        readyOn     = 1'b0;
        instr_ready = 1'b0;
        acksLeft    = 1;
        expAddrQ.push_back(32'h304);
        waitValid("redir_hold", 20);
        readyOn     = 1'b1;
        instr_ready = 1'b1;
        applyStimulus(32'h400);
        checkFlag("redir_hold_valid", instr_valid, 1'b0);
        checkOutput("redir_hold_addr", imem_addr, 32'h400);
        acksLeft = 1;
        expAddrQ.push_back(32'h400);
        pushInstr(32'h400, 32'hC0DE_0400);
        waitDrain("redir_hold_refetch", 20);

        // PC wrap from the top of the address space.
        applyStimulus(32'hFFFF_FFFC);
        checkOutput("wrap_drop_addr", imem_addr, 32'h404);
        acksLeft = 3;
        expAddrQ.push_back(32'h404);
        expAddrQ.push_back(32'hFFFF_FFFC);
        expAddrQ.push_back(32'h0);
        pushInstr(32'hFFFF_FFFC, 32'hC0DE_FFFC);
        pushInstr(32'h0, 32'hC0DE_0000);
        waitDrain("wrap", 40);
        checkOutput("wrap_next_addr", imem_addr, 32'h4);

        // Misaligned redirect target.
        applyStimulus(32'h202);
`ifdef FETCH_MISALIGN_CHECK_EN
        acksLeft = 1;
        expAddrQ.push_back(32'h4);
        waitDrain("misalign_drop", 20);
        checkFlag("misalign_error", fetch_error, 1'b1);
        checkFlag("misalign_req", imem_req, 1'b0);
        checkFlag("misalign_valid", instr_valid, 1'b0);
        tick();
        checkFlag("misalign_req_held", imem_req, 1'b0);
        applyStimulus(32'h500);
        checkFlag("misalign_recover_error", fetch_error, 1'b0);
        checkOutput("misalign_recover_addr", imem_addr, 32'h500);
`else
        checkFlag("misalign_error", fetch_error, 1'b0);
        acksLeft = 2;
        expAddrQ.push_back(32'h4);
        expAddrQ.push_back(32'h200);
        pushInstr(32'h200, 32'hC0DE_0200);
        waitDrain("misalign_masked", 20);
        checkOutput("misalign_next_addr", imem_addr, 32'h204);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
